// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring integer divider with start/busy/done handshake.
// Resolves BPC quotient bits per clock; signed mode truncates toward zero (C semantics).
module seq_nonrestoring_divider #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1,
  parameter int BPC    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0]        r_dvd, r_dvs, r_q;
  logic signed [WIDTH:0]   r_a, r_m;
  logic                    r_sd, r_sq;
  logic [CW-1:0]           r_cnt;

  logic                    w_accept, w_sd, w_sv, w_dz;
  logic signed [WIDTH:0]   w_a;
  logic [WIDTH-1:0]        w_q, w_rmag, w_qres, w_rres;

  function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // One non-restoring step: add/subtract decided by the sign of A before the shift.
  function automatic logic [2*WIDTH:0] nr_step(input logic signed [WIDTH:0] a,
                                              input logic [WIDTH-1:0]     q,
                                              input logic signed [WIDTH:0] m);
    logic signed [WIDTH:0] sh, an;
    sh = {a[WIDTH-1:0], q[WIDTH-1]};
    an = a[WIDTH] ? (sh + m) : (sh - m);
    return {an, q[WIDTH-2:0], ~an[WIDTH]};
  endfunction

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_sd = (SIGNED != 0) && r_dvd[WIDTH-1];
  assign w_sv = (SIGNED != 0) && r_dvs[WIDTH-1];

  always_comb begin
    w_a = r_a;
    w_q = r_q;
    for (int i = 0; i < BPC; i++) begin
      {w_a, w_q} = nr_step(w_a, w_q, r_m);
    end
  end

  // A zero divisor runs the normal schedule; results are overridden at FIX.
  assign w_dz   = (r_dvs == '0);
  assign w_rmag = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m[WIDTH-1:0]) : r_a[WIDTH-1:0];
  assign w_qres = w_dz ? '1    : cneg(r_sq, r_q);
  assign w_rres = w_dz ? r_dvd : cneg(r_sd, w_rmag);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_ITER;
      S_ITER:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = start ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FIX) begin
        quotient    <= w_qres;
        remainder   <= w_rres;
        div_by_zero <= w_dz;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_dvd <= dividend;
      r_dvs <= divisor;
    end
    case (r_state)
      S_LOAD: begin
        r_sd  <= w_sd;
        r_sq  <= w_sd ^ w_sv;
        r_a   <= '0;
        r_q   <= cneg(w_sd, r_dvd);
        r_m   <= {1'b0, cneg(w_sv, r_dvs)};
        r_cnt <= CW'(N - 1);
      end
      S_ITER: begin
        r_a   <= w_a;
        r_q   <= w_q;
        r_cnt <= r_cnt - CW'(1);
      end
      default: ;
    endcase
  end

  assign busy = (r_state == S_LOAD) || (r_state == S_ITER) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);

endmodule
